// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for the 5-stage PA-RISC core: register load enables,
// ID NOP insertion, delay-slot flush, EX operand forwarding and stall counting.
module pipeline_hazard_controller #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs_a,
   input  logic [REG_W-1:0] id_rs_b,
   input  logic             id_use_a,
   input  logic             id_use_b,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rf_le,
   input  logic             ex_load,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_rf_le,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_rf_le,
   input  logic             ex_branch_taken,
   input  logic             ex_nullify,
   input  logic             mem_busy,
   output logic             pc_le,
   output logic             if_id_le,
   output logic             if_id_flush,
   output logic             id_ex_le,
   output logic             ex_mem_le,
   output logic             mem_wb_le,
   output logic             nop_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             haz_a, haz_b, load_use;

   // Forward select for one operand; EX beats MEM beats WB, GR0 never forwarded.
   // A load in EX has no data yet, so it cannot be an EX forwarding source.
   function automatic logic [1:0] fwd_pick(
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] e_rd, input logic e_le, input logic e_ld,
      input logic [REG_W-1:0] m_rd, input logic m_le,
      input logic [REG_W-1:0] w_rd, input logic w_le
   );
      logic [1:0] sel;
      sel = 2'd0;
      if (rs != '0) begin
         if (e_le && !e_ld && (e_rd == rs))
            sel = 2'd1;
         else if (m_le && (m_rd == rs))
            sel = 2'd2;
         else if (w_le && (w_rd == rs))
            sel = 2'd3;
      end
      return sel;
   endfunction

   // Load-use detection against the instruction currently in EX.
   always_comb begin
      haz_a    = id_use_a & ex_load & ex_rf_le & (ex_rd == id_rs_a) & (id_rs_a != '0);
      haz_b    = id_use_b & ex_load & ex_rf_le & (ex_rd == id_rs_b) & (id_rs_b != '0);
      load_use = haz_a | haz_b;
   end

   // Next-state and enable decode; reset overrides every output combinationally.
   // MEM_WAIT on release decodes exactly like RUN, so the two share one branch.
   always_comb begin
      state_d     = state_q;
      pc_le       = 1'b1;
      if_id_le    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_le    = 1'b1;
      ex_mem_le   = 1'b1;
      mem_wb_le   = 1'b1;
      nop_sel     = 1'b0;
      fwd_a       = fwd_pick(id_rs_a, ex_rd, ex_rf_le, ex_load, mem_rd, mem_rf_le, wb_rd, wb_rf_le);
      fwd_b       = fwd_pick(id_rs_b, ex_rd, ex_rf_le, ex_load, mem_rd, mem_rf_le, wb_rd, wb_rf_le);

      if (mem_busy) begin
         pc_le     = 1'b0;
         if_id_le  = 1'b0;
         id_ex_le  = 1'b0;
         ex_mem_le = 1'b0;
         mem_wb_le = 1'b0;
         state_d   = MEM_WAIT;
      end else begin
         unique case (state_q)
            LOAD_STALL: state_d = RUN;
            default: begin
               if (ex_branch_taken) begin
                  if_id_flush = ex_nullify;
                  state_d     = RUN;
               end else if (load_use) begin
                  pc_le    = 1'b0;
                  if_id_le = 1'b0;
                  nop_sel  = 1'b1;
                  state_d  = LOAD_STALL;
               end else begin
                  state_d = RUN;
               end
            end
         endcase
      end

      if (!reset) begin
         pc_le       = 1'b0;
         if_id_le    = 1'b0;
         if_id_flush = 1'b0;
         id_ex_le    = 1'b0;
         ex_mem_le   = 1'b0;
         mem_wb_le   = 1'b0;
         nop_sel     = 1'b1;
         fwd_a       = 2'd0;
         fwd_b       = 2'd0;
         state_d     = RUN;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_le && (stall_count_q != '1))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= RUN;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central sequencing block for the 5-stage PA-RISC pipeline (PC front/back, IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Drives the load enables of every pipeline register and the ID control-mux NOP select.
- Generates the IF/ID flush for nullified delay slots and the EX operand forwarding selects.
- Sequences load-use bubbles and memory-wait freezes with a small FSM and a stall-cycle counter.

Parameters:
REG_W, 5, register specifier width (32 GRs)
CNT_W, 16, stall counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
id_rs_a  input  REG_W  ID source A specifier
id_rs_b  input  REG_W  ID source B specifier
id_use_a  input  1  ID instruction reads source A
id_use_b  input  1  ID instruction reads source B
ex_rd  input  REG_W  EX destination
ex_rf_le  input  1  EX instruction writes RF
ex_load  input  1  EX instruction is a load (L)
mem_rd  input  REG_W  MEM destination
mem_rf_le  input  1  MEM writes RF
wb_rd  input  REG_W  WB destination
wb_rf_le  input  1  WB writes RF
ex_branch_taken  input  1  branch/UB resolved taken in EX
ex_nullify  input  1  taken branch nullifies its delay slot
mem_busy  input  1  RAM not ready; freeze pipeline
pc_le  output  1  load enable, PC front and back
if_id_le  output  1  IF/ID load enable
if_id_flush  output  1  synchronous clear of IF/ID
id_ex_le  output  1  ID/EX load enable
ex_mem_le  output  1  EX/MEM load enable
mem_wb_le  output  1  MEM/WB load enable
nop_sel  output  1  1 = zero control signals into ID/EX
fwd_a  output  2  operand A select: 0 RF, 1 EX, 2 MEM, 3 WB
fwd_b  output  2  operand B select, same encoding
stall_count  output  CNT_W  cycles spent stalled or frozen

Behaviour:
- FSM states: RUN, LOAD_STALL, MEM_WAIT. State is registered; all other outputs are combinational from state and inputs, except stall_count.
- Reset asserted (reset=0), asynchronous:
  - state=RUN, stall_count=0.
  - Outputs forced to all LEs=0, if_id_flush=0, nop_sel=1, fwd_a=fwd_b=0.
- Hazard definitions:
  - hazA = id_use_a & ex_load & ex_rf_le & (ex_rd==id_rs_a) & (id_rs_a!=0).
  - hazB is the same using source B.
  - load_use = hazA | hazB.
- Forwarding, per operand, priority EX > MEM > WB:
  - EX match requires ex_rf_le & !ex_load & rd==rs & rs!=0.
  - MEM and WB matches require *_rf_le & rd==rs & rs!=0.
  - No match → 0.
  - GR0 is never forwarded.
- Priority each cycle: mem_busy > ex_branch_taken > load_use > normal.
- RUN:
  - mem_busy=1: all LEs=0, nop_sel=0, go MEM_WAIT.
  - ex_branch_taken=1: all LEs=1, nop_sel=0, stay RUN. if_id_flush=ex_nullify (delay slot in IF/ID is discarded only when nullified). A coincident load_use is ignored.
  - load_use=1:
    - pc_le=0 and if_id_le=0.
    - id_ex_le, ex_mem_le and mem_wb_le =1; nop_sel=1 (bubble).
    - Go LOAD_STALL.
  - Otherwise: all LEs=1, nop_sel=0, flush=0.
- LOAD_STALL: exactly one bubble has been inserted; the load is now in MEM and forwarding selects 2.
  - All LEs=1, nop_sel=0, return RUN.
  - A new load_use is not re-evaluated in this cycle.
  - mem_busy=1 takes precedence: freeze and go MEM_WAIT.
- MEM_WAIT:
  - All LEs=0, nop_sel=0, flush=0 while mem_busy=1.
  - On mem_busy=0 the outputs for that cycle are those of RUN evaluated normally, and the FSM goes RUN (or LOAD_STALL if load_use).
  - A branch-taken input held through the freeze takes effect on the release cycle only.
- stall_count:
  - Increments on each rising edge where pc_le=0 and reset is deasserted.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-stall or mid-freeze aborts immediately to RUN with the reset outputs; no bubble is replayed.

Test Plan:
- Reset, then no hazards for 5 cycles → all LEs=1, nop_sel=0, fwd_a=fwd_b=0, stall_count=0.
- EX ALU writes r5 and ID reads r5 on A; MEM also writes r5 → fwd_a=1 (EX wins). With EX removed → fwd_a=2. With only WB → 3. With rs=r0 → 0.
- EX load to r7, ID reads r7 on B:
  - Cycle 1: pc_le=0, if_id_le=0, nop_sel=1, state=LOAD_STALL.
  - Cycle 2: all LEs=1, fwd_b=2.
  - stall_count=1.
- ex_branch_taken=1 with ex_nullify=0 → if_id_flush=0. Repeat with ex_nullify=1 → if_id_flush=1, all LEs=1.
- mem_busy=1 for 3 cycles during a load_use → all LEs=0 for 3 cycles. Release → bubble inserted next, then RUN. stall_count=4.
- reset driven low mid-MEM_WAIT, asynchronously between edges → outputs immediately reset values. After release → RUN, stall_count=0.
